// File: rtl/simon_byte_host.sv
// Byte-stream host front end for the Simon32/64 core.
// Collects a command byte, an optional 64-bit key and a 32-bit block from
// the byte link. It then loads and runs the core, and returns the 32-bit
// result as four bytes, most significant byte first.
//
// Handshake (both byte ports): a byte moves on a rising clk edge where
// valid && ready are both high. The producer holds data stable while it
// waits for ready. s_ready and m_valid are registered.
module simon_byte_host #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             core_wait_data,
  output logic             core_cryp_decryp,
  output logic [3:0][15:0] core_k,
  output logic [1:0][15:0] core_text,
  input  logic             core_done,
  input  logic [1:0][15:0] core_result,
  output logic             busy,
  output logic             err_timeout,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    ST_CMD  = 3'd0,
    ST_KEY  = 3'd1,
    ST_TEXT = 3'd2,
    ST_RUN  = 3'd3,
    ST_SEND = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             wait_q, wait_d;
  logic             cryp_q, cryp_d;
  logic [3:0][15:0] k_q, k_d;
  logic [1:0][15:0] text_q, text_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             key_valid_q, key_valid_d;
  logic [2:0]       kcnt_q, kcnt_d;
  logic [1:0]       tcnt_q, tcnt_d;
  logic [1:0]       ocnt_q, ocnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [23:0]      res_q, res_d;

  logic       s_fire;
  logic       m_fire;
  logic [1:0] key_word;
  logic       text_word;

  assign s_fire    = s_valid && s_ready_q;
  assign m_fire    = m_valid_q && m_ready;
  // Words arrive most significant first, so the word index counts down.
  assign key_word  = ~kcnt_q[2:1];
  assign text_word = ~tcnt_q[1];

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    wait_d      = wait_q;
    cryp_d      = cryp_q;
    k_d         = k_q;
    text_d      = text_q;
    err_d       = err_q;
    key_valid_d = key_valid_q;
    kcnt_d      = kcnt_q;
    tcnt_d      = tcnt_q;
    ocnt_d      = ocnt_q;
    to_cnt_d    = to_cnt_q;
    res_d       = res_q;

    case (state_q)
      ST_CMD: begin
        s_ready_d = 1'b1;
        if (s_fire) begin
          cryp_d = s_data[0];
          err_d  = 1'b0;
          kcnt_d = 3'd0;
          tcnt_d = 2'd0;
          // Key reuse without a previously loaded key falls back to a key load.
          if (s_data[1] && key_valid_q) state_d = ST_TEXT;
          else                          state_d = ST_KEY;
        end
      end
      ST_KEY: begin
        if (s_fire) begin
          if (!kcnt_q[0]) k_d[key_word][15:8] = s_data;
          else            k_d[key_word][7:0]  = s_data;
          kcnt_d = kcnt_q + 3'd1;
          if (kcnt_q == 3'd7) begin
            key_valid_d = 1'b1;
            tcnt_d      = 2'd0;
            state_d     = ST_TEXT;
          end
        end
      end
      ST_TEXT: begin
        if (s_fire) begin
          if (!tcnt_q[0]) text_d[text_word][15:8] = s_data;
          else            text_d[text_word][7:0]  = s_data;
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd3) begin
            s_ready_d = 1'b0;
            wait_d    = 1'b0;
            to_cnt_d  = '0;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Done takes priority over a timeout in the same cycle.
        if (core_done) begin
          m_data_d  = core_result[1][15:8];
          res_d     = {core_result[1][7:0], core_result[0]};
          m_valid_d = 1'b1;
          wait_d    = 1'b1;
          ocnt_d    = 2'd0;
          state_d   = ST_SEND;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d     = 1'b1;
          wait_d    = 1'b1;
          s_ready_d = 1'b1;
          state_d   = ST_CMD;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_SEND: begin
        if (m_fire) begin
          if (ocnt_q == 2'd3) begin
            m_valid_d = 1'b0;
            s_ready_d = 1'b1;
            state_d   = ST_CMD;
          end else begin
            m_data_d = res_q[23:16];
            res_d    = {res_q[15:0], 8'h00};
            ocnt_d   = ocnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_CMD;
      end
    endcase

    busy_d = (state_d != ST_CMD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_CMD;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 8'h00;
      wait_q      <= 1'b1;
      cryp_q      <= 1'b0;
      k_q         <= '0;
      text_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      key_valid_q <= 1'b0;
      kcnt_q      <= 3'd0;
      tcnt_q      <= 2'd0;
      ocnt_q      <= 2'd0;
      to_cnt_q    <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      wait_q      <= wait_d;
      cryp_q      <= cryp_d;
      k_q         <= k_d;
      text_q      <= text_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      key_valid_q <= key_valid_d;
      kcnt_q      <= kcnt_d;
      tcnt_q      <= tcnt_d;
      ocnt_q      <= ocnt_d;
      to_cnt_q    <= to_cnt_d;
      res_q       <= res_d;
    end
  end

  assign s_ready          = s_ready_q;
  assign m_valid          = m_valid_q;
  assign m_data           = m_data_q;
  assign core_wait_data   = wait_q;
  assign core_cryp_decryp = cryp_q;
  assign core_k           = k_q;
  assign core_text        = text_q;
  assign busy             = busy_q;
  assign err_timeout      = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_simon_byte_host.sv
// Bench for simon_byte_host: byte-frame driver, Simon32/64 core stub,
// and an output scoreboard fed from a Simon32/64 reference model.
module tb_simon_byte_host;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready;
  logic             core_wait_data;
  logic             core_cryp_decryp;
  logic [3:0][15:0] core_k;
  logic [1:0][15:0] core_text;
  logic             core_done;
  logic [1:0][15:0] core_result;
  logic             busy;
  logic             err_timeout;
  logic [2:0]       dbg_state;

  simon_byte_host dut (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .core_wait_data   (core_wait_data),
    .core_cryp_decryp (core_cryp_decryp),
    .core_k           (core_k),
    .core_text        (core_text),
    .core_done        (core_done),
    .core_result      (core_result),
    .busy             (busy),
    .err_timeout      (err_timeout),
    .dbg_state        (dbg_state)
  );

  localparam int TIMEOUT = 1024;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         out_cnt = 0;
  int         rdy_mode = 0;
  int         bp_base = 0;
  int         bp_stall = 0;
  logic       stub_hang = 1'b0;
  logic       model_kv = 1'b0;
  logic [63:0] model_key = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Simon32/64 reference model ----------------
  function automatic logic [15:0] rol16(input logic [15:0] v, input int r);
    return (v << r) | (v >> (16 - r));
  endfunction

  function automatic logic [31:0] simon(input logic [63:0] key, input logic [31:0] blk,
                                        input logic enc);
    logic [15:0] k[32];
    logic [15:0] x, y, t;
    logic [30:0] zc;
    zc = 31'b1111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rol16(k[i-1], 13) ^ k[i-3];
      t = t ^ rol16(t, 15);
      k[i] = 16'hFFFC ^ {15'd0, zc[30 - ((i - 4) % 31)]} ^ k[i-4] ^ t;
    end
    x = blk[31:16];
    y = blk[15:0];
    if (enc) begin
      for (int i = 0; i < 32; i++) begin
        t = x;
        x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ k[i];
        y = t;
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        t = y;
        y = x ^ (rol16(y, 1) & rol16(y, 8)) ^ rol16(y, 2) ^ k[i];
        x = t;
      end
    end
    return {x, y};
  endfunction

  // ---------------- core stub ----------------
  initial begin
    int lat;
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk); #1;
      if (rst && core_wait_data === 1'b0 && !stub_hang) begin
        lat = $urandom_range(0, 20);
        repeat (lat) begin @(posedge clk); #1; end
        core_result = simon(core_k, core_text, core_cryp_decryp);
        core_done   = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        for (int i = 0; i < 50 && core_wait_data === 1'b0; i++) begin @(posedge clk); #1; end
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: m_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if ((out_cnt - bp_base) == 1 && bp_stall < 5 && m_valid) begin
            m_ready = 1'b0;
            bp_stall++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      if (hold_prev) begin
        check("m_hold_valid", m_valid, 1'b1);
        check("m_hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("m_unexpected_byte", 1'b1, 1'b0);
        end else begin
          check("m_data", m_data, exp_q.pop_front());
        end
        out_cnt++;
      end
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int   gap;
    logic ok;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    ok      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    check("s_accept", ok, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic check_reset_values();
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_wait_data", core_wait_data, 1'b1);
    check("rst_cryp", core_cryp_decryp, 1'b0);
    check("rst_core_k", core_k, 64'h0);
    check("rst_core_text", core_text, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst      = 1'b1;
    model_kv = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [63:0] key,
                           input logic [31:0] blk, input logic hang,
                           input logic use_const, input logic [31:0] const_exp);
    logic        reuse;
    logic [31:0] exp;
    logic        fin;
    int          n;
    send_byte(cmd);
    @(negedge clk);
    check("cmd_busy", busy, 1'b1);
    check("cmd_err_clear", err_timeout, 1'b0);
    check("cmd_cryp", core_cryp_decryp, cmd[0]);
    @(posedge clk); #1;
    reuse = cmd[1] && model_kv;
    if (!reuse) begin
      for (int i = 0; i < 8; i++) send_byte(key[63 - 8*i -: 8]);
      model_key = key;
      model_kv  = 1'b1;
    end
    for (int i = 0; i < 4; i++) send_byte(blk[31 - 8*i -: 8]);
    exp = use_const ? const_exp : simon(model_key, blk, cmd[0]);
    if (!hang) for (int i = 0; i < 4; i++) exp_q.push_back(exp[31 - 8*i -: 8]);
    @(negedge clk);
    check("wait_fall", core_wait_data, 1'b0);
    check("core_k", core_k, model_key);
    check("core_text", core_text, blk);
    check("run_s_ready", s_ready, 1'b0);
    if (hang) begin
      n = (core_wait_data == 1'b0) ? 1 : 0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (core_wait_data == 1'b0) n++;
        else break;
      end
      check("timeout_run_cycles", n, TIMEOUT);
      check("timeout_err", err_timeout, 1'b1);
      check("timeout_wait_data", core_wait_data, 1'b1);
      check("timeout_s_ready", s_ready, 1'b1);
      check("timeout_busy", busy, 1'b0);
      check("timeout_m_valid", m_valid, 1'b0);
    end else begin
      fin = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (exp_q.size() == 0 && !busy) begin fin = 1'b1; break; end
        if (busy && (m_valid || !core_wait_data)) check("busy_s_ready", s_ready, 1'b0);
      end
      check("frame_done", fin, 1'b1);
      check("end_m_valid", m_valid, 1'b0);
      check("end_err", err_timeout, 1'b0);
      check("end_s_ready", s_ready, 1'b1);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst = 1'b1;

    // Known-answer encrypt, then decrypt with the retained key.
    run_frame(8'h01, 64'h1918_1110_0908_0100, 32'h6565_6877, 1'b0, 1'b1, 32'hC69B_E9BB);
    run_frame(8'h02, 64'h0, 32'hC69B_E9BB, 1'b0, 1'b1, 32'h6565_6877);

    // Key reuse requested right after reset must still load a key.
    do_reset();
    run_frame(8'h03, {$urandom, $urandom}, $urandom, 1'b0, 1'b0, 32'h0);

    // Output backpressure on the second result byte.
    rdy_mode = 2;
    bp_base  = out_cnt;
    bp_stall = 0;
    run_frame(8'h01, 64'h1918_1110_0908_0100, 32'h6565_6877, 1'b0, 1'b1, 32'hC69B_E9BB);
    rdy_mode = 0;

    // Core never finishes; the following command clears the error.
    stub_hang = 1'b1;
    run_frame(8'h01, {$urandom, $urandom}, $urandom, 1'b1, 1'b0, 32'h0);
    stub_hang = 1'b0;
    run_frame(8'h00, {$urandom, $urandom}, $urandom, 1'b0, 1'b0, 32'h0);

    // Reset part-way through the key.
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    do_reset();
    run_frame(8'h01, 64'h1918_1110_0908_0100, 32'h6565_6877, 1'b0, 1'b1, 32'hC69B_E9BB);

    // Random frames with random downstream stalls.
    rdy_mode = 1;
    for (int f = 0; f < 10; f++) begin
      run_frame(8'($urandom), {$urandom, $urandom}, $urandom, 1'b0, 1'b0, 32'h0);
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_byte_host.md
Name: simon_byte_host

Overview:
- Byte-stream front end that drives the Simon32/64 core from the host side of its interface.
- Collects a command byte, an optional 64-bit key and a 32-bit block over a valid/ready byte input.
- Loads the core, releases `wait_data`, waits for `done`, then returns the 32-bit result as 4 bytes over a valid/ready byte output.
- Sits between the system byte link (UART/SPI deframer) and the cipher core.

Parameters:
- `TIMEOUT_CYCLES`, 1024, maximum cycles in RUN waiting for core done before abort.
- `TO_W`, 11, width of timeout counter; must satisfy 2^TO_W > `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset
- `s_data`  in  8  input byte
- `s_valid`  in  1  input byte valid
- `s_ready`  out  1  block accepts input byte
- `m_data`  out  8  output byte
- `m_valid`  out  1  output byte valid
- `m_ready`  in  1  downstream accepts output byte
- `core_wait_data`  out  1  to core `wait_data`; 1 = hold/load, 0 = run
- `core_cryp_decryp`  out  1  to core: 1 encrypt, 0 decrypt
- `core_k`  out  16x[3:0]  to core `k_in`
- `core_text`  out  16x[1:0]  to core `text_in`
- `core_done`  in  1  from core `done`
- `core_result`  in  16x[1:0]  from core `crypt_out`
- `busy`  out  1  high in every state except CMD
- `err_timeout`  out  1  sticky timeout flag

Behaviour:
- Interface: one clock; reset is synchronous and active-low. On the `clk` edge with `rst`=0, every output and all state take their reset values.
- Reset values: `s_ready`=0, `m_valid`=0, `m_data`=0, `core_wait_data`=1, `core_cryp_decryp`=0, `core_k`=0, `core_text`=0, `busy`=0, `err_timeout`=0, `key_valid`=0, state=CMD.
- Handshake rules:
  - A byte transfers when valid && ready on a rising edge.
  - `m_data` is held stable while `m_valid` && !`m_ready`.
  - `s_ready` is registered: 1 in CMD, KEY and TEXT; 0 otherwise.
- Command byte:
  - bit0 = cryp_decryp.
  - bit1 = key_reuse.
  - bits[7:2] are ignored.
- Byte order is big-endian per word:
  - Key: `k_in[3]` hi, `k_in[3]` lo, `k_in[2]` hi … `k_in[0]` lo (8 bytes).
  - Text: `text_in[1]` hi, lo, `text_in[0]` hi, lo (4 bytes).
  - Result: `crypt_out[1]` hi, lo, `crypt_out[0]` hi, lo (4 bytes).
- States and transitions:
  - CMD:
    - On command accept, latch `core_cryp_decryp` and clear `err_timeout`.
    - If key_reuse=1 and `key_valid`=1, go to TEXT; otherwise go to KEY.
    - key_reuse=1 with `key_valid`=0 is treated as key_reuse=0.
  - KEY:
    - A 3-bit counter places each accepted byte into `core_k`.
    - After the 8th byte, set `key_valid`=1 and go to TEXT.
  - TEXT:
    - A 2-bit counter fills `core_text`.
    - After the 4th byte, go to RUN.
    - `core_wait_data` falls to 0 on the cycle after the last text byte is accepted.
  - RUN:
    - `core_wait_data`=0 and the timeout counter increments each cycle.
    - On `core_done`=1: capture `core_result` into the output shift register, set `core_wait_data`=1 next cycle, go to SEND.
    - If the counter reaches `TIMEOUT_CYCLES` without done: set `err_timeout`=1, set `core_wait_data`=1, go to CMD, emit no bytes.
    - If done and timeout occur in the same cycle, done wins.
  - SEND:
    - `m_valid`=1 starting the cycle after done is sampled.
    - Emit 4 bytes; after the 4th handshake, `m_valid`=0 next cycle and go to CMD.
- `core_k`, `core_text` and `core_cryp_decryp` change only in CMD/KEY/TEXT; they are stable throughout RUN.
- `s_valid` during RUN/SEND is ignored; `s_ready`=0.
- Reset mid-operation: any state returns to CMD, partial frame discarded, `key_valid` cleared, `core_wait_data`=1.
- Byte counters wrap only via the state change; no overflow path exists.

Test Plan:
- Encrypt, Simon32/64 vector:
  - Stimulus: bytes 01, 19 18 11 10 09 08 01 00, 65 65 68 77.
  - Response: `core_k`={1918,1110,0908,0100}, `core_wait_data` 1→0, core done → `m_data` C6 9B E9 BB, `busy` low after last byte.
- Decrypt with key_reuse:
  - Stimulus: bytes 02, C6 9B E9 BB right after the previous test.
  - Response: no KEY phase, output 65 65 68 77.
- key_reuse after reset:
  - Stimulus: `rst` pulse, then command 03.
  - Response: block enters KEY and expects 8 key bytes.
- Backpressure:
  - Stimulus: `m_ready` held 0 for 5 cycles on byte 2.
  - Response: `m_data`=9B stable; order unchanged; no byte lost or duplicated.
- Timeout:
  - Stimulus: core stub never asserts done.
  - Response: after 1024 RUN cycles, `err_timeout`=1, `core_wait_data`=1, no `m_valid`, `s_ready`=1; next command byte clears `err_timeout`.
- Reset mid-frame:
  - Stimulus: `rst`=0 after 5 key bytes.
  - Response: all outputs return to reset values; a fresh full frame then produces the correct result.
